// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 data-memory access stage.
package lc3_mem_pkg;

    // Memory operation requested by execute; codes 5-7 behave as NONE.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        LD   = 3'd1,
        ST   = 3'd2,
        LDI  = 3'd3,
        STI  = 3'd4
    } mem_op_e;

    // Access sequencer states; the encoding is visible on mem_state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD1  = 2'b01,
        RD2  = 2'b10,
        WR   = 2'b11
    } mem_state_e;

    // Load result returned when the memory never answers.
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // True for the opcodes that start a memory access.
    function automatic logic is_access_op(input logic [2:0] op);
        return (op == LD) || (op == ST) || (op == LDI) || (op == STI);
    endfunction

endpackage

// File: rtl/lc3_mem_access_if.sv
// Execute/writeback request side and data-memory port of the access stage.
interface lc3_mem_access_if;

    // Request from execute
    logic        req_valid;
    logic [2:0]  mem_op;
    logic [15:0] mem_addr;
    logic [15:0] st_data;

    // Data-memory port
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        mem_req;
    logic [15:0] Data_dout;
    logic        complete_data;

    // Results to writeback / controller / monitor
    logic [15:0] memout;
    logic        done;
    logic        busy;
    logic        err;
    logic [1:0]  mem_state;

    // The access stage itself.
    modport master (
        input  req_valid, mem_op, mem_addr, st_data, Data_dout, complete_data,
        output Data_addr, Data_din, Data_rd, mem_req, memout, done, busy, err, mem_state
    );

    // Execute, memory and controller surrounding the stage.
    modport slave (
        output req_valid, mem_op, mem_addr, st_data, Data_dout, complete_data,
        input  Data_addr, Data_din, Data_rd, mem_req, memout, done, busy, err, mem_state
    );

endinterface

// File: rtl/lc3_mem_wait_timer.sv
// Per-access wait counter; expire flags the last allowed wait cycle.
module lc3_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;

    // Count waiting cycles; clear restarts the count for a new access.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 data-memory access stage: sequences LD, ST, LDI and STI against
// a handshaked data memory, with a per-access timeout.
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic              clk,
    input logic              reset,
    lc3_mem_access_if.master bus
);

    mem_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [15:0] st_data_q, st_data_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] memout_q, memout_d;
    logic        rd_q, rd_d;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        tmr_clear, tmr_expire;
    logic        finish, timed_out;

    lc3_mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .enable((state_q != IDLE) && !bus.complete_data),
        .expire(tmr_expire)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        st_data_d = st_data_q;
        addr_d    = addr_q;
        din_d     = din_q;
        memout_d  = memout_q;
        rd_d      = rd_q;
        req_d     = req_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        tmr_clear = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && is_access_op(bus.mem_op)) begin
                    op_d      = mem_op_e'(bus.mem_op);
                    st_data_d = bus.st_data;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    req_d     = 1'b1;
                    tmr_clear = 1'b1;
                    addr_d    = bus.mem_addr;
                    if (op_d == ST) begin
                        din_d   = bus.st_data;
                        rd_d    = 1'b0;
                        state_d = WR;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                if (bus.complete_data) begin
                    case (op_q)
                        LDI: begin
                            addr_d    = bus.Data_dout;
                            rd_d      = 1'b1;
                            tmr_clear = 1'b1;
                            state_d   = RD2;
                        end
                        STI: begin
                            addr_d    = bus.Data_dout;
                            din_d     = st_data_q;
                            rd_d      = 1'b0;
                            tmr_clear = 1'b1;
                            state_d   = WR;
                        end
                        default: begin
                            memout_d = bus.Data_dout;
                            finish   = 1'b1;
                        end
                    endcase
                end else if (tmr_expire) begin
                    timed_out = 1'b1;
                end
            end
            RD2: begin
                if (bus.complete_data) begin
                    memout_d = bus.Data_dout;
                    finish   = 1'b1;
                end else if (tmr_expire) begin
                    timed_out = 1'b1;
                end
            end
            WR: begin
                if (bus.complete_data) begin
                    finish = 1'b1;
                end else if (tmr_expire) begin
                    timed_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout abandons whatever remains of the operation.
        if (timed_out) begin
            err_d    = 1'b1;
            memout_d = TIMEOUT_DATA;
            finish   = 1'b1;
        end

        // Common return to IDLE; address and write data keep their last values.
        if (finish) begin
            done_d    = 1'b1;
            state_d   = IDLE;
            req_d     = 1'b0;
            busy_d    = 1'b0;
            rd_d      = 1'b1;
            tmr_clear = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= NONE;
            st_data_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            memout_q  <= '0;
            rd_q      <= 1'b1;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            st_data_q <= st_data_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            memout_q  <= memout_d;
            rd_q      <= rd_d;
            req_q     <= req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.Data_addr = addr_q;
    assign bus.Data_din  = din_q;
    assign bus.Data_rd   = rd_q;
    assign bus.mem_req   = req_q;
    assign bus.memout    = memout_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.mem_state = state_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Self-checking bench for lc3_mem_access: directed table, hand-written
// multi-cycle sequences and randomized operations against a memory model.
module tb_lc3_mem_access;
    import lc3_mem_pkg::*;

    localparam int T = 8;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic [15:0] din;
    } acc_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat;
        logic [15:0] exp_out;
        int          exp_cyc;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3_mem_access_if mif();

    lc3_mem_access #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (mif)
    );

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    acc_t        acc_q[$];
    acc_t        exp_q[$];
    logic [15:0] model_memout;
    int          lat = 1;
    bit          resp_en = 1'b1;
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers each access with a one-cycle complete_data after `lat` cycles.
    initial begin
        int pos = 0;
        mif.complete_data = 1'b0;
        mif.Data_dout     = '0;
        forever begin
            @(negedge clk);
            if (resp_en && mif.mem_req === 1'b1 && !reset) begin
                if (mif.complete_data) begin
                    mif.complete_data = 1'b0;
                    pos = 0;
                end
                if (pos == lat) begin
                    mif.complete_data = 1'b1;
                    if (mif.Data_rd) mif.Data_dout = mem[mif.Data_addr];
                    else             mem[mif.Data_addr] = mif.Data_din;
                    acc_q.push_back('{mif.Data_addr, mif.Data_rd, mif.Data_din});
                end else begin
                    pos++;
                end
            end else begin
                mif.complete_data = 1'b0;
                pos = 0;
            end
        end
    end

    // Count done pulses independently of the transaction tasks.
    initial forever begin
        @(negedge clk);
        if (mif.done === 1'b1) done_cnt++;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: the effect of one operation in terms of memory words.
    task automatic model_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data,
                            input int k, input bit responds,
                            output logic [15:0] exp_out, output logic exp_err, output int exp_cyc);
        logic [15:0] p;
        exp_q.delete();
        exp_err = 1'b0;
        exp_cyc = 0;
        if (!responds || k >= T) begin
            model_memout = TIMEOUT_DATA;
            exp_err      = 1'b1;
            exp_cyc      = T;
        end else begin
            case (op)
                3'd1: begin
                    exp_q.push_back('{addr, 1'b1, 16'h0});
                    model_memout = ref_mem[addr];
                    exp_cyc = k + 1;
                end
                3'd2: begin
                    exp_q.push_back('{addr, 1'b0, data});
                    ref_mem[addr] = data;
                    exp_cyc = k + 1;
                end
                3'd3: begin
                    p = ref_mem[addr];
                    exp_q.push_back('{addr, 1'b1, 16'h0});
                    exp_q.push_back('{p, 1'b1, 16'h0});
                    model_memout = ref_mem[p];
                    exp_cyc = 2 * (k + 1);
                end
                3'd4: begin
                    p = ref_mem[addr];
                    exp_q.push_back('{addr, 1'b1, 16'h0});
                    exp_q.push_back('{p, 1'b0, data});
                    ref_mem[p] = data;
                    exp_cyc = 2 * (k + 1);
                end
                default: exp_cyc = 0;
            endcase
        end
        exp_out = model_memout;
    endtask

    // Issue one valid operation, wait for done and check everything observable.
    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] addr,
                          input logic [15:0] data, input int k, input bit have_tbl,
                          input logic [15:0] tbl_out, input int tbl_cyc, input logic tbl_err);
        logic [15:0] exp_out;
        logic        exp_err;
        int          exp_cyc;
        int          cyc = 0;
        bit          got = 1'b0;
        int          dc0;
        lat = k;
        acc_q.delete();
        model_op(op, addr, data, k, resp_en, exp_out, exp_err, exp_cyc);
        @(negedge clk);
        mif.req_valid = 1'b1;
        mif.mem_op    = op;
        mif.mem_addr  = addr;
        mif.st_data   = data;
        dc0 = done_cnt;
        @(posedge clk); #1;
        check({name, " busy@accept"}, mif.busy, 1'b1);
        check({name, " err@accept"}, mif.err, 1'b0);
        check({name, " mem_req@accept"}, mif.mem_req, 1'b1);
        while (!got && cyc < 200) begin
            // Requests presented while busy must be ignored.
            mif.req_valid = 1'($urandom_range(0, 1));
            mif.mem_op    = 3'($urandom);
            mif.mem_addr  = 16'($urandom);
            mif.st_data   = 16'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (mif.done === 1'b1) got = 1'b1;
        end
        mif.req_valid = 1'b0;
        check({name, " done seen"}, got, 1'b1);
        check({name, " latency"}, cyc, exp_cyc);
        check({name, " memout"}, mif.memout, exp_out);
        check({name, " err"}, mif.err, exp_err);
        check({name, " busy@done"}, mif.busy, 1'b0);
        check({name, " mem_req@done"}, mif.mem_req, 1'b0);
        check({name, " Data_rd@done"}, mif.Data_rd, 1'b1);
        if (have_tbl) begin
            check({name, " tbl memout"}, mif.memout, tbl_out);
            check({name, " tbl latency"}, cyc, tbl_cyc);
            check({name, " tbl err"}, mif.err, tbl_err);
        end
        @(posedge clk); #1;
        check({name, " done width"}, mif.done, 1'b0);
        check({name, " done count"}, done_cnt - dc0, 1);
        check({name, " access count"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            check({name, " acc addr"}, acc_q[i].addr, exp_q[i].addr);
            check({name, " acc rd"}, acc_q[i].rd, exp_q[i].rd);
            if (!exp_q[i].rd) check({name, " acc din"}, acc_q[i].din, exp_q[i].din);
        end
    endtask

    // NONE and undefined opcodes: no access, no done, err left alone.
    task automatic invalid_ops(input logic exp_err);
        logic [2:0] bad [3];
        int dc0;
        bad = '{3'd0, 3'd5, 3'd7};
        for (int i = 0; i < 3; i++) begin
            dc0 = done_cnt;
            @(negedge clk);
            mif.req_valid = 1'b1;
            mif.mem_op    = bad[i];
            mif.mem_addr  = 16'h3000;
            @(posedge clk); #1;
            mif.req_valid = 1'b0;
            check("invalid state", mif.mem_state, IDLE);
            check("invalid mem_req", mif.mem_req, 1'b0);
            check("invalid busy", mif.busy, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            check("invalid no done", done_cnt - dc0, 0);
            check("invalid memout", mif.memout, model_memout);
            check("invalid err sticky", mif.err, exp_err);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, " state"}, mif.mem_state, IDLE);
        check({name, " Data_addr"}, mif.Data_addr, 16'h0);
        check({name, " Data_din"}, mif.Data_din, 16'h0);
        check({name, " Data_rd"}, mif.Data_rd, 1'b1);
        check({name, " mem_req"}, mif.mem_req, 1'b0);
        check({name, " memout"}, mif.memout, 16'h0);
        check({name, " done"}, mif.done, 1'b0);
        check({name, " busy"}, mif.busy, 1'b0);
        check({name, " err"}, mif.err, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [15:0] e_out;
        logic        e_err;
        int          e_cyc;
        int          dc0;
        int          waited;
        int          seq[5];
        int          exp_seq[5];
        logic [2:0]  rop;
        int          rk;

        vecs[0] = '{3'd1, 16'h3000, 16'h0000, 1, 16'h1234, 2, 1'b0};
        vecs[1] = '{3'd2, 16'h3010, 16'hBEEF, 1, 16'h1234, 2, 1'b0};
        vecs[2] = '{3'd3, 16'h3020, 16'h0000, 1, 16'h00AA, 4, 1'b0};
        vecs[3] = '{3'd4, 16'h3030, 16'h7777, 1, 16'h00AA, 4, 1'b0};
        vecs[4] = '{3'd1, 16'h3010, 16'h0000, 3, 16'hBEEF, 4, 1'b0};
        vecs[5] = '{3'd3, 16'h3020, 16'h0000, 2, 16'h00AA, 6, 1'b0};
        vecs[6] = '{3'd1, 16'h3000, 16'h0000, 7, 16'h1234, 8, 1'b0};
        vecs[7] = '{3'd2, 16'h3040, 16'h1111, 8, 16'hDEAD, 8, 1'b1};
        vecs[8] = '{3'd1, 16'h5000, 16'h0000, 1, 16'h7777, 2, 1'b0};
        exp_seq = '{1, 1, 2, 2, 0};

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
        mem[16'h3020] = 16'h4000; ref_mem[16'h3020] = 16'h4000;
        mem[16'h4000] = 16'h00AA; ref_mem[16'h4000] = 16'h00AA;
        mem[16'h3030] = 16'h5000; ref_mem[16'h3030] = 16'h5000;
        model_memout = 16'h0;

        mif.req_valid = 1'b0;
        mif.mem_op    = 3'd0;
        mif.mem_addr  = 16'h0;
        mif.st_data   = 16'h0;
        reset = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed table (TIMEOUT_CYCLES = 8).
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].lat,
                   1'b1, vecs[i].exp_out, vecs[i].exp_cyc, vecs[i].exp_err);
            if (vecs[i].exp_err) invalid_ops(1'b1);
        end
        check("STI stored word", mem[16'h5000], 16'h7777);

        // Timeout with a silent memory, then a normal request clears err.
        resp_en = 1'b0;
        run_op("silent LD", 3'd1, 16'h3000, 16'h0, 1, 1'b1, 16'hDEAD, T, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("err sticky idle", mif.err, 1'b1);
        resp_en = 1'b1;
        run_op("LD after timeout", 3'd1, 16'h3000, 16'h0, 1, 1'b1, 16'h1234, 2, 1'b0);

        // LDI state walk with one-cycle memory.
        lat = 1;
        acc_q.delete();
        model_op(3'd3, 16'h3020, 16'h0, 1, 1'b1, e_out, e_err, e_cyc);
        @(negedge clk);
        mif.req_valid = 1'b1;
        mif.mem_op    = 3'd3;
        mif.mem_addr  = 16'h3020;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) mif.req_valid = 1'b0;
            seq[c] = int'(mif.mem_state);
            if (c == 2) check("LDI second addr", mif.Data_addr, 16'h4000);
        end
        for (int c = 0; c < 5; c++) check($sformatf("LDI state[%0d]", c), seq[c], exp_seq[c]);
        check("LDI walk done", mif.done, 1'b1);
        check("LDI walk memout", mif.memout, e_out);
        @(posedge clk); #1;

        // Asynchronous reset while in RD2 of an LDI.
        lat = 3;
        acc_q.delete();
        @(negedge clk);
        mif.req_valid = 1'b1;
        mif.mem_op    = 3'd3;
        mif.mem_addr  = 16'h3020;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        waited = 0;
        while (mif.mem_state !== RD2 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach RD2", mif.mem_state, RD2);
        dc0 = done_cnt;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_values("mid reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid reset no done", done_cnt - dc0, 0);
        check("mid reset idle", mif.mem_state, IDLE);
        model_memout = 16'h0;
        run_op("LD after reset", 3'd1, 16'h3000, 16'h0, 1, 1'b1, 16'h1234, 2, 1'b0);

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                invalid_ops(mif.err);
            end else begin
                rop = 3'($urandom_range(1, 4));
                rk  = ($urandom_range(0, 9) == 0) ? T : $urandom_range(1, 4);
                run_op($sformatf("rnd%0d", n), rop, 16'($urandom), 16'($urandom), rk,
                       1'b0, 16'h0, 0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
